// File: rtl/axi3_slave_mem_if.sv
// AXI3 bus bundle between a master and the axi3_slave_mem responder.
interface axi3_slave_mem_if #(
    parameter int DATA_BUSWIDTH = 32
);
    localparam int NB = DATA_BUSWIDTH / 8;

    logic [3:0]               awid;
    logic [31:0]              awaddr;
    logic [3:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic [1:0]               awlock;
    logic [2:0]               awprot;
    logic [3:0]               awcache;
    logic                     awvalid;
    logic                     awready;

    logic [3:0]               wid;
    logic [DATA_BUSWIDTH-1:0] wdata;
    logic [NB-1:0]            wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;

    logic [3:0]               bid;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    logic [3:0]               arid;
    logic [31:0]              araddr;
    logic [3:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic [1:0]               arlock;
    logic [2:0]               arprot;
    logic [3:0]               arcache;
    logic                     arvalid;
    logic                     arready;

    logic [3:0]               rid;
    logic [DATA_BUSWIDTH-1:0] rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awprot, awcache, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arprot, arcache, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awprot, awcache, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arprot, arcache, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi3_slave_mem.sv
// AXI3 memory responder: one outstanding write burst and one outstanding
// read burst, served concurrently from a byte-addressable word RAM.
module axi3_slave_mem #(
    parameter int DATA_BUSWIDTH = 32,
    parameter int MEM_DEPTH     = 256
) (
    input logic             aclk,
    input logic             aresetn,   // active-high despite the name
    axi3_slave_mem_if.slave bus
);
    localparam int          NB        = DATA_BUSWIDTH / 8;
    localparam int          ADDR_LSB  = $clog2(NB);
    localparam int          IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * NB);
    localparam logic [1:0]  OKAY      = 2'b00;
    localparam logic [1:0]  SLVERR    = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // Next beat address for FIXED / INCR / WRAP bursts.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << size;
        mask = (({28'd0, len} + 32'd1) * step) - 32'd1;
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | ((addr + step) & mask);
            default: next_addr = addr + step;
        endcase
    endfunction

    // Burst attributes that make every beat of the burst an error.
    function automatic logic burst_err(input logic [31:0] addr, input logic [3:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step;
        step      = 32'd1 << size;
        burst_err = 1'b0;
        if (int'(size) > ADDR_LSB) burst_err = 1'b1;
        if (burst == 2'b11) burst_err = 1'b1;
        if (burst == 2'b10) begin
            if (!(len inside {4'd1, 4'd3, 4'd7, 4'd15})) burst_err = 1'b1;
            if ((addr & (step - 32'd1)) != 32'd0) burst_err = 1'b1;
        end
    endfunction

    function automatic logic beat_oob(input logic [31:0] addr);
        beat_oob = (addr >= MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        word_idx = IDX_W'(addr >> ADDR_LSB);
    endfunction

    logic [DATA_BUSWIDTH-1:0] mem_q [MEM_DEPTH];

    logic                     ready_en_q, ready_en_d;

    w_state_e                 w_state_q, w_state_d;
    logic [3:0]               awid_q, awid_d;
    logic [31:0]              waddr_q, waddr_d;
    logic [3:0]               awlen_q, awlen_d;
    logic [2:0]               awsize_q, awsize_d;
    logic [1:0]               awburst_q, awburst_d;
    logic [3:0]               wcnt_q, wcnt_d;
    logic                     wburst_err_q, wburst_err_d;
    logic                     werr_q, werr_d;
    logic [1:0]               bresp_q, bresp_d;

    r_state_e                 r_state_q, r_state_d;
    logic [3:0]               arid_q, arid_d;
    logic [31:0]              raddr_q, raddr_d;
    logic [3:0]               arlen_q, arlen_d;
    logic [2:0]               arsize_q, arsize_d;
    logic [1:0]               arburst_q, arburst_d;
    logic [3:0]               rcnt_q, rcnt_d;
    logic                     rburst_err_q, rburst_err_d;
    logic [DATA_BUSWIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]               rresp_q, rresp_d;

    logic                     aw_ready, ar_ready;
    logic                     w_beat_err, w_is_last, w_last_bad;
    logic                     mem_we;
    logic [IDX_W-1:0]         mem_widx;
    logic [DATA_BUSWIDTH-1:0] mem_word_d;
    logic [31:0]              r_nxt;
    logic                     r_err;

    // Lock, protection, cache and write-ID fields carry no meaning for this memory.
    logic unused_ok;
    assign unused_ok = ^{bus.awlock, bus.awprot, bus.awcache,
                         bus.arlock, bus.arprot, bus.arcache, bus.wid};

    assign aw_ready    = ready_en_q && (w_state_q == W_IDLE);
    assign ar_ready    = ready_en_q && (r_state_q == R_IDLE);
    assign bus.awready = aw_ready;
    assign bus.wready  = (w_state_q == W_DATA);
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.bid     = awid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = ar_ready;
    assign bus.rvalid  = (r_state_q == R_DATA);
    assign bus.rid     = arid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = (r_state_q == R_DATA) && (rcnt_q == arlen_q);

    // Ready outputs stay low during reset and come up on the first edge after it.
    assign ready_en_d = 1'b1;

    // Write FSM: address capture, strobed beat writes, response hold.
    always_comb begin
        w_state_d    = w_state_q;
        awid_d       = awid_q;
        waddr_d      = waddr_q;
        awlen_d      = awlen_q;
        awsize_d     = awsize_q;
        awburst_d    = awburst_q;
        wcnt_d       = wcnt_q;
        wburst_err_d = wburst_err_q;
        werr_d       = werr_q;
        bresp_d      = bresp_q;
        w_beat_err   = wburst_err_q | beat_oob(waddr_q);
        w_is_last    = (wcnt_q == awlen_q);
        w_last_bad   = (bus.wlast != w_is_last);
        mem_we       = 1'b0;
        mem_widx     = word_idx(waddr_q);
        mem_word_d   = mem_q[mem_widx];
        for (int b = 0; b < NB; b++) begin
            if (bus.wstrb[b]) mem_word_d[8*b +: 8] = bus.wdata[8*b +: 8];
        end
        case (w_state_q)
            W_IDLE: begin
                if (aw_ready && bus.awvalid) begin
                    awid_d       = bus.awid;
                    waddr_d      = bus.awaddr;
                    awlen_d      = bus.awlen;
                    awsize_d     = bus.awsize;
                    awburst_d    = bus.awburst;
                    wcnt_d       = 4'd0;
                    werr_d       = 1'b0;
                    wburst_err_d = burst_err(bus.awaddr, bus.awlen, bus.awsize, bus.awburst);
                    w_state_d    = W_DATA;
                end
            end
            W_DATA: begin
                if (bus.wvalid) begin
                    mem_we  = !w_beat_err;
                    wcnt_d  = wcnt_q + 4'd1;
                    waddr_d = next_addr(waddr_q, awlen_q, awsize_q, awburst_q);
                    werr_d  = werr_q | w_beat_err | w_last_bad;
                    // The beat count, not wlast, closes the burst.
                    if (w_is_last) begin
                        bresp_d   = (werr_q | w_beat_err | w_last_bad) ? SLVERR : OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    bresp_d   = OKAY;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM: prefetch the word for the current beat into rdata_q.
    always_comb begin
        r_state_d    = r_state_q;
        arid_d       = arid_q;
        raddr_d      = raddr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        arburst_d    = arburst_q;
        rcnt_d       = rcnt_q;
        rburst_err_d = rburst_err_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        r_nxt        = next_addr(raddr_q, arlen_q, arsize_q, arburst_q);
        r_err        = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_ready && bus.arvalid) begin
                    arid_d       = bus.arid;
                    raddr_d      = bus.araddr;
                    arlen_d      = bus.arlen;
                    arsize_d     = bus.arsize;
                    arburst_d    = bus.arburst;
                    rcnt_d       = 4'd0;
                    rburst_err_d = burst_err(bus.araddr, bus.arlen, bus.arsize, bus.arburst);
                    r_err        = rburst_err_d | beat_oob(bus.araddr);
                    rdata_d      = r_err ? '0 : mem_q[word_idx(bus.araddr)];
                    rresp_d      = r_err ? SLVERR : OKAY;
                    r_state_d    = R_DATA;
                end
            end
            R_DATA: begin
                if (bus.rready) begin
                    if (rcnt_q == arlen_q) begin
                        rdata_d   = '0;
                        rresp_d   = OKAY;
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d = r_nxt;
                        rcnt_d  = rcnt_q + 4'd1;
                        r_err   = rburst_err_q | beat_oob(r_nxt);
                        rdata_d = r_err ? '0 : mem_q[word_idx(r_nxt)];
                        rresp_d = r_err ? SLVERR : OKAY;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Control and channel state registers for both paths.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            ready_en_q   <= 1'b0;
            w_state_q    <= W_IDLE;
            awid_q       <= '0;
            waddr_q      <= '0;
            awlen_q      <= '0;
            awsize_q     <= '0;
            awburst_q    <= '0;
            wcnt_q       <= '0;
            wburst_err_q <= 1'b0;
            werr_q       <= 1'b0;
            bresp_q      <= OKAY;
            r_state_q    <= R_IDLE;
            arid_q       <= '0;
            raddr_q      <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
            rcnt_q       <= '0;
            rburst_err_q <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= OKAY;
        end else begin
            ready_en_q   <= ready_en_d;
            w_state_q    <= w_state_d;
            awid_q       <= awid_d;
            waddr_q      <= waddr_d;
            awlen_q      <= awlen_d;
            awsize_q     <= awsize_d;
            awburst_q    <= awburst_d;
            wcnt_q       <= wcnt_d;
            wburst_err_q <= wburst_err_d;
            werr_q       <= werr_d;
            bresp_q      <= bresp_d;
            r_state_q    <= r_state_d;
            arid_q       <= arid_d;
            raddr_q      <= raddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arburst_q    <= arburst_d;
            rcnt_q       <= rcnt_d;
            rburst_err_q <= rburst_err_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
        end
    end

    // Memory array: cleared on reset, one merged word written per accepted good beat.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[mem_widx] <= mem_word_d;
        end
    end
endmodule

// File: tb/tb_axi3_slave_mem.sv
// Directed bench for axi3_slave_mem with hand-computed expectations.
module tb_axi3_slave_mem;
    logic aclk = 1'b0;
    logic aresetn;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd [16];
    logic [1:0]  rr [16];
    logic [15:0] rlv;
    logic [3:0]  got_bid, got_rid;
    logic [1:0]  got_bresp;

    axi3_slave_mem_if #(.DATA_BUSWIDTH(32)) bus ();

    axi3_slave_mem #(.DATA_BUSWIDTH(32), .MEM_DEPTH(256)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input bit drop_wlast, input int bstall);
        int n;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
        bus.awburst = burst; bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 50) begin @(posedge aclk); #1; n++; end
        if (n >= 50) chk("aw_timeout", 0, 1);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata  = wd[i];
            bus.wstrb  = ws[i];
            bus.wlast  = (i == int'(len)) && !drop_wlast;
            bus.wvalid = 1'b1;
            n = 0;
            while (!bus.wready && n < 50) begin @(posedge aclk); #1; n++; end
            if (n >= 50) chk("w_timeout", 0, 1);
            @(posedge aclk); #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        for (int k = 0; k < bstall; k++) begin
            chk("bstall_bvalid", bus.bvalid, 1);
            chk("bstall_awready", bus.awready, 0);
            @(posedge aclk); #1;
        end
        bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 50) begin @(posedge aclk); #1; n++; end
        if (n >= 50) chk("b_timeout", 0, 1);
        got_bid   = bus.bid;
        got_bresp = bus.bresp;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int stall_beat, input logic [31:0] stall_data);
        int n;
        rlv = '0;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
        bus.arburst = burst; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin @(posedge aclk); #1; n++; end
        if (n >= 50) chk("ar_timeout", 0, 1);
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!bus.rvalid && n < 50) begin @(posedge aclk); #1; n++; end
            if (n >= 50) chk("r_timeout", 0, 1);
            if (i == stall_beat) begin
                bus.rready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge aclk); #1;
                    chk("stall_rvalid", bus.rvalid, 1);
                    chk("stall_rdata", bus.rdata, stall_data);
                    chk("stall_rlast", bus.rlast, (i == int'(len)));
                end
                bus.rready = 1'b1;
            end
            rd[i]   = bus.rdata;
            rr[i]   = bus.rresp;
            rlv[i]  = bus.rlast;
            got_rid = bus.rid;
            @(posedge aclk); #1;
        end
        bus.rready = 1'b0;
        chk("r_end_rvalid", bus.rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b1;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = '0; bus.awprot = '0; bus.awcache = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock = '0; bus.arprot = '0; bus.arcache = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        // Reset with bus idle
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_ctrl", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast,
                         bus.bresp, bus.rresp, bus.bid, bus.rid}, 0);
        chk("rst_rdata", bus.rdata, 0);
        aresetn = 1'b0;
        #1;
        chk("rel_awready_early", bus.awready, 0);
        @(posedge aclk); #1;
        chk("rel_awready", bus.awready, 1);
        chk("rel_arready", bus.arready, 1);

        // INCR write then INCR read back
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
        axi_write(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 1'b0, 0);
        chk("incr_bid", got_bid, 5);
        chk("incr_bresp", got_bresp, 0);
        axi_read(4'd6, 32'h10, 4'd3, 3'd2, 2'b01, -1, 32'h0);
        for (int i = 0; i < 4; i++) chk("incr_rdata", rd[i], 32'hA0 + i);
        chk("incr_rlast", rlv[3:0], 4'b1000);
        chk("incr_rresp", {rr[0], rr[1], rr[2], rr[3]}, 0);
        chk("incr_rid", got_rid, 6);

        // Partial strobe over existing word
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        axi_write(4'd1, 32'h20, 4'd0, 3'd2, 2'b01, 1'b0, 0);
        wd[0] = 32'hDEADBEEF; ws[0] = 4'b0011;
        axi_write(4'd2, 32'h20, 4'd0, 3'd2, 2'b01, 1'b0, 0);
        chk("strb_bresp", got_bresp, 0);
        axi_read(4'd3, 32'h20, 4'd0, 3'd2, 2'b01, -1, 32'h0);
        chk("strb_rdata", rd[0], 32'h1122BEEF);
        chk("strb_rlast", rlv[0], 1);

        // WRAP and FIXED reads
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0 + i; ws[i] = 4'hF; end
        axi_write(4'd7, 32'h30, 4'd3, 3'd2, 2'b01, 1'b0, 0);
        axi_read(4'd8, 32'h38, 4'd3, 3'd2, 2'b10, -1, 32'h0);
        chk("wrap_b0", rd[0], 32'hC2);
        chk("wrap_b1", rd[1], 32'hC3);
        chk("wrap_b2", rd[2], 32'hC0);
        chk("wrap_b3", rd[3], 32'hC1);
        chk("wrap_rresp", {rr[0], rr[1], rr[2], rr[3]}, 0);
        axi_read(4'd9, 32'h34, 4'd2, 3'd2, 2'b00, -1, 32'h0);
        for (int i = 0; i < 3; i++) chk("fixed_rdata", rd[i], 32'hC1);
        chk("fixed_rlast", rlv[2:0], 3'b100);

        // Backpressure on R and B
        axi_read(4'd10, 32'h10, 4'd3, 3'd2, 2'b01, 1, 32'hA1);
        for (int i = 0; i < 4; i++) chk("stall_burst", rd[i], 32'hA0 + i);
        wd[0] = 32'h77; ws[0] = 4'hF;
        axi_write(4'd11, 32'h50, 4'd0, 3'd2, 2'b01, 1'b0, 3);
        chk("bstall_bresp", got_bresp, 0);
        chk("bstall_bid", got_bid, 11);

        // Error cases
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        axi_write(4'd12, 32'h400, 4'd0, 3'd2, 2'b01, 1'b0, 0);
        chk("oob_bresp", got_bresp, 2'b10);
        axi_read(4'd0, 32'h0, 4'd0, 3'd2, 2'b01, -1, 32'h0);
        chk("oob_no_alias", rd[0], 0);
        axi_read(4'd0, 32'h400, 4'd0, 3'd2, 2'b01, -1, 32'h0);
        chk("oob_rresp", rr[0], 2'b10);
        chk("oob_rdata", rd[0], 0);
        axi_read(4'd1, 32'h10, 4'd1, 3'd2, 2'b11, -1, 32'h0);
        chk("rsvd_rresp", {rr[0], rr[1]}, 4'b1010);
        chk("rsvd_rdata", {rd[0], rd[1]}, 0);
        axi_read(4'd2, 32'h30, 4'd2, 3'd2, 2'b10, -1, 32'h0);
        chk("wraplen_rresp", {rr[0], rr[1], rr[2]}, 6'b101010);
        for (int i = 0; i < 2; i++) begin wd[i] = 32'h99; ws[i] = 4'hF; end
        axi_write(4'd3, 32'h60, 4'd1, 3'd2, 2'b01, 1'b1, 0);
        chk("wlast_bresp", got_bresp, 2'b10);

        // Reset in the middle of a read burst
        bus.araddr = 32'h10; bus.arlen = 4'd3; bus.arsize = 3'd2; bus.arburst = 2'b01;
        bus.arid = 4'd4; bus.arvalid = 1'b1; bus.rready = 1'b0;
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        chk("mid_rvalid", bus.rvalid, 1);
        #2 aresetn = 1'b1;
        #1;
        chk("mid_rst_ctrl", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
                             bus.rlast, bus.rresp, bus.rid}, 0);
        chk("mid_rst_rdata", bus.rdata, 0);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        wd[0] = 32'h55; ws[0] = 4'hF;
        axi_write(4'd13, 32'h40, 4'd0, 3'd2, 2'b01, 1'b0, 0);
        chk("post_bresp", got_bresp, 0);
        axi_read(4'd14, 32'h40, 4'd0, 3'd2, 2'b01, -1, 32'h0);
        chk("post_rdata", rd[0], 32'h55);
        axi_read(4'd15, 32'h10, 4'd0, 3'd2, 2'b01, -1, 32'h0);
        chk("post_cleared", rd[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi3_slave_mem.md
Name: axi3_slave_mem

Overview:
- AXI3 slave-side memory responder; drives the responder half of the team's AXI3 bus (awready, wready, b*, arready, r*).
- Serves write and read bursts into an internal byte-addressable, word-organised RAM.
- Write path and read path are independent; each handles one outstanding transaction.
- Instantiated in the verification environment opposite the master driver, and usable as a simple on-chip AXI3 memory.

Parameters:
- DATA_BUSWIDTH, 32, width of wdata/rdata in bits (32 or 64); bytes per beat NB = DATA_BUSWIDTH/8.
- MEM_DEPTH, 256, number of DATA_BUSWIDTH-wide words; valid byte range is 0 .. MEM_DEPTH*NB-1.

Ports:
- aclk  in  1  clock; all logic on posedge.
- aresetn  in  1  asynchronous, active-high reset (name kept per codebase).
- awid in 4; awaddr in 32; awlen in 4; awsize in 3; awburst in 2; awlock in 2; awprot in 3; awcache in 4; awvalid in 1; awready out 1.
- wid in 4; wdata in DATA_BUSWIDTH; wstrb in NB; wlast in 1; wvalid in 1; wready out 1.
- bid out 4; bresp out 2; bvalid out 1; bready in 1.
- arid in 4; araddr in 32; arlen in 4; arsize in 3; arburst in 2; arlock in 2; arprot in 3; arcache in 4; arvalid in 1; arready out 1.
- rid out 4; rdata out DATA_BUSWIDTH; rresp out 2; rlast out 1; rvalid out 1; rready in 1.

Behaviour:
- Reset (async assert):
  - All outputs 0; both FSMs go to IDLE; memory cleared to 0.
  - Any in-flight burst is aborted with no response.
  - awready and arready rise on the first posedge after release.
- Write FSM:
  - States: W_IDLE (awready=1) -> W_DATA (wready=1) -> W_RESP (bvalid=1).
  - AW handshake (awvalid & awready) latches awid, awaddr, awlen, awsize, awburst; awready drops next cycle. awlock, awprot and awcache are ignored.
  - Each wvalid & wready beat writes the bytes whose wstrb bit is 1 to word addr/NB, at the byte lanes given by wstrb.
  - Burst length is awlen+1. The beat with count == awlen ends the burst regardless of wlast.
  - W_RESP: bid = latched awid. Hold bvalid and bresp until bready; then return to W_IDLE, with awready=1 on the next cycle.
  - wid is not checked.
- Address sequencing (both paths): step = 2^size.
  - FIXED (00): address constant.
  - INCR (01): addr += step.
  - WRAP (10): wrap boundary W = (len+1)*step; next = (addr & ~(W-1)) | ((addr+step) & (W-1)).
- Error rules: bresp/rresp are OKAY=00 or SLVERR=10.
  - Burst-level SLVERR: size > log2(NB); burst == 11; WRAP with len not in {1,3,7,15}; WRAP with addr not step-aligned.
  - Beat-level SLVERR: byte address >= MEM_DEPTH*NB.
  - Write error: no memory update for that beat. bresp = SLVERR if any beat errored or wlast disagrees with the final-beat position.
  - Read error: rdata = 0 for that beat; rresp is set per beat.
- Read FSM:
  - States: R_IDLE (arready=1) -> R_DATA.
  - AR handshake latches AR fields; rvalid=1 on the next cycle with rid = arid, rdata = full memory word at current address, rresp, and rlast = (beat == arlen).
  - Beat advances only on rvalid & rready. While rready is low, rdata, rresp and rlast hold stable.
  - After the last beat is accepted: rvalid=0, return to R_IDLE, arready=1 on the next cycle.
- Concurrency:
  - Reads and writes proceed simultaneously.
  - Same-word read and write on the same edge: read returns the pre-write data.
  - A write becomes visible to reads from the cycle after its beat is accepted.
- Ready signals are independent of the incoming valid signals (no combinational valid->ready paths).

Test Plan:
- Reset with bus idle -> all outputs 0 during reset; awready=1 and arready=1 one cycle after release.
- INCR write, awaddr=0x10, awlen=3, awsize=2, wdata 0xA0..0xA3, wstrb=F -> bvalid with bid=awid, bresp=00. Then INCR read of same range, arlen=3 -> rdata A0,A1,A2,A3; rlast only on beat 4; rresp=00.
- Write to 0x20 with wstrb=0011, wdata=0xDEADBEEF over prior 0x11223344 -> read returns 0x1122BEEF.
- WRAP read, araddr=0x38, arlen=3, arsize=2 -> addresses 0x38, 0x3C, 0x30, 0x34. FIXED read, arlen=2 -> same word three times.
- rready held low 3 cycles mid-burst -> rdata, rlast and rvalid stable; no beat lost. bready held low -> bvalid stays 1 and awready stays 0.
- Write to awaddr = MEM_DEPTH*NB -> bresp=10 and memory unchanged. awburst=11 read -> every rresp=10. Reset asserted mid-burst -> outputs 0 and next transaction completes normally.
